// File: rtl/cc_deserializer.sv
// Cache-line deserializer: collects eight 64-bit read beats into one 512-bit line and pushes {offset, line} into a FIFO.
// Optional rlast protocol checking is enabled by defining CC_DESER_RLAST_CHECK_EN.
module cc_deserializer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_valid_i,
  input  logic [5:0]   miss_offset_i,
  output logic         miss_ready_o,
  input  logic [63:0]  mem_rdata_i,
  input  logic         mem_rlast_i,
  input  logic         mem_rvalid_i,
  output logic         mem_rready_o,
  input  logic         fifo_full_i,
  output logic         fifo_wren_o,
  output logic [517:0] fifo_wdata_o,
  output logic         err_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] PUSH    = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q;
  logic [5:0]   offset_q;
  logic [511:0] line_q;
  logic         capture;
  logic         beat_acc;

  // Handshake outputs depend only on registered state (plus FIFO backpressure in PUSH).
  assign mem_rready_o = (state_q == COLLECT);
  assign fifo_wren_o  = (state_q == PUSH) && !fifo_full_i;
  assign miss_ready_o = (state_q == IDLE) || fifo_wren_o;
  assign fifo_wdata_o = {offset_q, line_q};

  assign capture  = miss_valid_i && miss_ready_o;
  assign beat_acc = mem_rvalid_i && mem_rready_o;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_valid_i) state_d = COLLECT;
      COLLECT: if (beat_acc && (cnt_q == 3'd7)) state_d = PUSH;
      PUSH:    if (fifo_wren_o) state_d = miss_valid_i ? COLLECT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      offset_q <= 6'd0;
      // NOTE: the line register is reset because the FIFO data port must read zero after reset.
      line_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        offset_q <= miss_offset_i;
        cnt_q    <= 3'd0;
      end
      if (beat_acc) begin
        line_q[{cnt_q, 6'd0} +: 64] <= mem_rdata_i;
        cnt_q                       <= cnt_q + 3'd1;
      end
    end
  end

`ifdef CC_DESER_RLAST_CHECK_EN
  logic err_q;

  // rlast must be high exactly on the eighth beat; the data path ignores it either way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (beat_acc && (mem_rlast_i != (cnt_q == 3'd7))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_rlast;

  assign unused_rlast = mem_rlast_i;
  assign err_o        = 1'b0;
`endif

endmodule

// File: doc/cc_deserializer.md
CC_DESERIALIZER -- requirements
Module: CC_DESERIALIZER

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port miss_valid_i  input  1  miss request from cache control, line fill required.
REQ-004 SHALL have port miss_offset_i  input  6  byte offset of requested word within 64B line.
REQ-005 SHALL have port miss_ready_o  output  1  request accepted when miss_valid_i & miss_ready_o.
REQ-006 SHALL have port mem_rdata_i  input  64  memory read beat, line-aligned INCR order (word 0 first).
REQ-007 SHALL have port mem_rlast_i  input  1  final beat marker.
REQ-008 SHALL have port mem_rvalid_i  input  1  beat valid.
REQ-009 SHALL have port mem_rready_o  output  1  beat accepted when mem_rvalid_i & mem_rready_o.
REQ-010 SHALL have port fifo_full_i  input  1  downstream line FIFO full.
REQ-011 SHALL have port fifo_wren_o  output  1  FIFO push strobe.
REQ-012 SHALL have port fifo_wdata_o  output  518  {offset[5:0], line[511:0]}; word k at bits [64k+63:64k].
REQ-013 SHALL have port err_o  output  1  sticky rlast protocol error (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, PUSH; reset state IDLE.
REQ-015 IDLE: miss_ready_o=1, mem_rready_o=0; on miss_valid_i capture miss_offset_i, clear beat counter, go COLLECT.
REQ-016 COLLECT: mem_rready_o=1, miss_ready_o=0; each accepted beat stored into word register [cnt], 3-bit cnt increments.
REQ-017 Beat with cnt==7 accepted SHALL transition to PUSH next cycle; cnt wraps to 0.
REQ-018 COLLECT with mem_rvalid_i=0 SHALL hold all state (no timeout).
REQ-019 PUSH: fifo_wren_o = !fifo_full_i; fifo_wdata_o stable and valid for whole PUSH state; mem_rready_o=0.
REQ-020 PUSH with fifo_full_i=1 SHALL hold in PUSH, fifo_wren_o=0, data unchanged.
REQ-021 PUSH with write done: miss_ready_o=1 in same cycle; if miss_valid_i also 1, capture new offset and go directly COLLECT, else go IDLE.
REQ-022 Latency: fifo_wren_o asserts earliest the cycle after the 8th beat handshake (beat 8 at cycle N -> push at N+1).
REQ-023 fifo_wren_o SHALL be 0 in IDLE and COLLECT; exactly one push per accepted miss.
REQ-024 Offset field stored unmodified; only bits [5:3] select critical word downstream; bits [2:0] pass through.
REQ-025 Outputs fifo_wren_o, mem_rready_o, miss_ready_o SHALL be decoded from registered state only (no combinational path from mem_rvalid_i).

Reset
REQ-026 On rst_n=0 at clock edge: state IDLE, cnt 0, offset 0, all word registers 0, err_o 0.
REQ-027 Reset mid-COLLECT or mid-PUSH SHALL abandon the line; no fifo_wren_o the cycle after reset.
REQ-028 Outputs after reset: miss_ready_o=1, mem_rready_o=0, fifo_wren_o=0, fifo_wdata_o=0, err_o=0.

Configuration
REQ-029 Macro CC_DESER_RLAST_CHECK_EN SHALL gate protocol checking.
REQ-030 Defined: err_o set (sticky until reset) if mem_rlast_i=1 on an accepted beat with cnt!=7, or mem_rlast_i=0 on beat with cnt==7; data path unaffected, FSM still counts 8 beats.
REQ-031 Not defined: mem_rlast_i ignored, err_o tied 0, no check logic synthesized.

Verification
REQ-032 Reset, miss offset 0x10, beats 0x1000..0x1007 back-to-back, FIFO not full -> one push next cycle after beat 8, wdata[517:512]=0x10, word k=0x1000+k.
REQ-033 Same as 032 with mem_rvalid_i toggling every other cycle -> identical push contents, push one cycle after final beat.
REQ-034 fifo_full_i=1 for 5 cycles in PUSH -> fifo_wren_o=0 for 5 cycles, data stable, push on 6th cycle, exactly one push.
REQ-035 Push cycle with miss_valid_i=1 offset 0x38 -> miss_ready_o=1 same cycle, next state COLLECT, second line pushed with offset 0x38.
REQ-036 With CC_DESER_RLAST_CHECK_EN: rlast=1 on beat 4 -> err_o=1 next cycle and stays 1; line still pushed after beat 8; without macro err_o=0.
REQ-037 rst_n=0 after 3 beats -> no push, miss_ready_o=1 after reset, next full line pushes correctly.
